// File: rtl/lane_misr_harness_pkg.sv
// Shared definitions for lane_misr_harness.
//   state_e      : harness FSM states (idle, accepting beats, draining pipeline, done pulse)
//   MODE_*       : per-lane transform selectors
//   fold_chunks  : number of SIGW-bit chunks needed to cover a LANES*W vector
package lane_misr_harness_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_XOR  = 2'd1;
    localparam logic [1:0] MODE_ADD  = 2'd2;
    localparam logic [1:0] MODE_ROT  = 2'd3;

    function automatic int unsigned fold_chunks(input int unsigned lanes,
                                                input int unsigned w,
                                                input int unsigned sigw);
        return (lanes * w + sigw - 1) / sigw;
    endfunction

endpackage

// File: rtl/lane_xform.sv
// Combinational per-lane transform.
//   lane_i : this lane's data
//   nbr_i  : neighbouring lane (index (IDX+1) mod LANES)
//   mode_i : transform select (pass / xor / add / rotate)
//   lane_o : transformed lane
// IDX is the lane index; it fixes the rotate amount (IDX mod W).
module lane_xform
    import lane_misr_harness_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned IDX = 0
) (
    input  logic [W-1:0] lane_i,
    input  logic [W-1:0] nbr_i,
    input  logic [1:0]   mode_i,
    output logic [W-1:0] lane_o
);

    localparam int unsigned ROT = IDX % W;

    // Upper half of the doubled word shifted left is the left rotation.
    logic [2*W-1:0] rot_dbl;

    always_comb begin
        rot_dbl = {lane_i, lane_i} << ROT;
        lane_o  = lane_i;
        case (mode_i)
            MODE_PASS: lane_o = lane_i;
            MODE_XOR:  lane_o = lane_i ^ nbr_i;
            MODE_ADD:  lane_o = lane_i + nbr_i;
            MODE_ROT:  lane_o = rot_dbl[2*W-1:W];
            default:   lane_o = lane_i;
        endcase
    end

endmodule

// File: rtl/lane_misr_harness.sv
// Observation harness: accepts CYCLES multi-lane beats over valid/ready, transforms them
// per lane, delays them through a DEPTH-stage pipeline and compacts the result into a MISR.
//   clk, rst   : clock and synchronous active-high reset
//   start      : run request, honoured only when idle; mode is captured with it
//   din*       : beat data (lane i = din[i*W +: W]) with valid/ready handshake
//   busy, done : run in progress / one-cycle completion pulse
//   count, sig : beats accepted this run / current signature
module lane_misr_harness
    import lane_misr_harness_pkg::*;
#(
    parameter int unsigned     W      = 8,
    parameter int unsigned     LANES  = 2,
    parameter int unsigned     DEPTH  = 2,
    parameter int unsigned     CYCLES = 4,
    parameter int unsigned     SIGW   = 16,
    parameter logic [SIGW-1:0] POLY   = 16'h1021,
    parameter logic [SIGW-1:0] SEED   = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [LANES*W-1:0]           din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(CYCLES+1)-1:0]  count,
    output logic [SIGW-1:0]              sig
);

    localparam int unsigned    CW       = $clog2(CYCLES + 1);
    localparam int unsigned    DW       = LANES * W;
    localparam int unsigned    CHUNKS   = fold_chunks(LANES, W, SIGW);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

    state_e            st_q, st_d;
    logic [1:0]        mode_q, mode_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SIGW-1:0]   sig_q, sig_d;
    logic [DW-1:0]     stg_q [DEPTH];
    logic [DW-1:0]     stg_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;

    logic [DW-1:0]          xf;
    logic                   accept;
    logic [CHUNKS*SIGW-1:0] padded;
    logic [SIGW-1:0]        fold;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_xform #(
            .W   (W),
            .IDX (i)
        ) u_xform (
            .lane_i (din[i*W +: W]),
            .nbr_i  (din[((i + 1) % LANES)*W +: W]),
            .mode_i (mode_q),
            .lane_o (xf[i*W +: W])
        );
    end

    assign din_ready = (st_q == StRun);
    assign busy      = (st_q == StRun) || (st_q == StDrain);
    assign done      = (st_q == StDone);
    assign count     = count_q;
    assign sig       = sig_q;
    assign accept    = din_valid & din_ready;

    // Pipeline: stage 0 takes the transformed beat, later stages are pure delay.
    always_comb begin
        vld_d[0] = accept;
        stg_d[0] = accept ? xf : stg_q[0];
        for (int unsigned k = 1; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k-1];
            stg_d[k] = stg_q[k-1];
        end
    end

    // XOR-fold of the last stage, zero-padded to whole chunks; chunk 0 is the LSBs.
    always_comb begin
        padded         = '0;
        padded[DW-1:0] = stg_q[DEPTH-1];
        fold           = '0;
        for (int unsigned c = 0; c < CHUNKS; c++) begin
            fold = fold ^ padded[c*SIGW +: SIGW];
        end
    end

    always_comb begin
        st_d    = st_q;
        mode_d  = mode_q;
        count_d = count_q;
        sig_d   = sig_q;

        if (vld_q[DEPTH-1]) begin
            sig_d = {sig_q[SIGW-2:0], 1'b0} ^ (sig_q[SIGW-1] ? POLY : '0) ^ fold;
        end

        case (st_q)
            StIdle: begin
                if (start) begin
                    st_d    = StRun;
                    sig_d   = SEED;
                    count_d = '0;
                    mode_d  = mode;
                end
            end
            StRun: begin
                if (accept) begin
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                    if (count_q == CNT_LAST) begin
                        st_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // No accepts in drain, so an all-zero next valid vector means the
                // final absorb is happening on this edge.
                if (vld_d == '0) begin
                    st_d = StDone;
                end
            end
            StDone:  st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            mode_q  <= '0;
            count_q <= '0;
            sig_q   <= SEED;
            vld_q   <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            st_q    <= st_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            sig_q   <= sig_d;
            vld_q   <= vld_d;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

endmodule
